operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 114 +++++++++++
 tb/tb_operand_fetch.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboards in-flight destinations, stalls on RAW/WAW hazards,
// bypasses same-cycle writeback data, and holds a one-entry registered operand bundle.
module operand_fetch #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [4:0]      rs1_addr_in,
   input  logic [4:0]      rs2_addr_in,
   input  logic [4:0]      rd_addr_in,
   input  logic            uses_rs1,
   input  logic            uses_rs2,
   input  logic            rd_write,
   output logic [4:0]      regA_addr_out,
   output logic [4:0]      regB_addr_out,
   input  logic [XLEN-1:0] regA_data_in,
   input  logic [XLEN-1:0] regB_data_in,
   input  logic            wb_valid,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            op_valid,
   input  logic            op_ready,
   output logic [XLEN-1:0] opA_out,
   output logic [XLEN-1:0] opB_out,
   output logic [4:0]      op_rd_out,
   output logic            op_rd_write_out
);

   logic [31:0]     busy;
   logic [31:0]     busy_next;
   logic            wb_hit_a;
   logic            wb_hit_b;
   logic            wb_hit_d;
   logic            haz_a;
   logic            haz_b;
   logic            haz_d;
   logic            out_free;
   logic            accept;
   logic            rd_wr_eff;
   logic [XLEN-1:0] op_a_sel;
   logic [XLEN-1:0] op_b_sel;

   assign regA_addr_out = rs1_addr_in;
   assign regB_addr_out = rs2_addr_in;

   // A writeback landing this cycle resolves the hazard on its register.
   assign wb_hit_a = wb_valid && (wb_addr == rs1_addr_in);
   assign wb_hit_b = wb_valid && (wb_addr == rs2_addr_in);
   assign wb_hit_d = wb_valid && (wb_addr == rd_addr_in);

   assign haz_a = uses_rs1 && (rs1_addr_in != 5'd0) && busy[rs1_addr_in] && !wb_hit_a;
   assign haz_b = uses_rs2 && (rs2_addr_in != 5'd0) && busy[rs2_addr_in] && !wb_hit_b;
   assign haz_d = rd_write && (rd_addr_in != 5'd0) && busy[rd_addr_in] && !wb_hit_d;

   assign rd_wr_eff   = rd_write && (rd_addr_in != 5'd0);
   assign out_free    = !op_valid || op_ready;
   assign issue_ready = reset && out_free && !haz_a && !haz_b && !haz_d && !flush;
   assign accept      = issue_valid && issue_ready;

   always_comb begin
      op_a_sel = '0;
      if (uses_rs1 && (rs1_addr_in != 5'd0)) begin
         op_a_sel = wb_hit_a ? wb_data : regA_data_in;
      end
   end

   always_comb begin
      op_b_sel = '0;
      if (uses_rs2 && (rs2_addr_in != 5'd0)) begin
         op_b_sel = wb_hit_b ? wb_data : regB_data_in;
      end
   end

   // Set is applied after clear so a new writer of the same register keeps it busy.
   always_comb begin
      busy_next = busy;
      if (wb_valid && (wb_addr != 5'd0)) begin
         busy_next[wb_addr] = 1'b0;
      end
      if (accept && rd_wr_eff) begin
         busy_next[rd_addr_in] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy            <= '0;
         op_valid        <= 1'b0;
         opA_out         <= '0;
         opB_out         <= '0;
         op_rd_out       <= '0;
         op_rd_write_out <= 1'b0;
      end else if (flush) begin
         busy     <= '0;
         op_valid <= 1'b0;
      end else begin
         busy <= busy_next;
         if (accept) begin
            op_valid        <= 1'b1;
            opA_out         <= op_a_sel;
            opB_out         <= op_b_sel;
            op_rd_out       <= rd_addr_in;
            op_rd_write_out <= rd_wr_eff;
         end else if (op_ready) begin
            op_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic
// checked against a scoreboard/regfile reference model.
module tb_operand_fetch;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic            issue_valid;
   logic            issue_ready;
   logic [4:0]      rs1_addr_in;
   logic [4:0]      rs2_addr_in;
   logic [4:0]      rd_addr_in;
   logic            uses_rs1;
   logic            uses_rs2;
   logic            rd_write;
   logic [4:0]      regA_addr_out;
   logic [4:0]      regB_addr_out;
   logic [XLEN-1:0] regA_data_in;
   logic [XLEN-1:0] regB_data_in;
   logic            wb_valid;
   logic [4:0]      wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            flush;
   logic            op_valid;
   logic            op_ready;
   logic [XLEN-1:0] opA_out;
   logic [XLEN-1:0] opB_out;
   logic [4:0]      op_rd_out;
   logic            op_rd_write_out;

   int n_cmp = 0;
   int n_err = 0;

   // bench-side register file feeding the combinational read ports
   logic [XLEN-1:0] rf [32];
   assign regA_data_in = rf[regA_addr_out];
   assign regB_data_in = rf[regB_addr_out];

   // reference model state
   bit              m_busy [32];
   bit              m_opv;
   logic [XLEN-1:0] m_a;
   logic [XLEN-1:0] m_b;
   logic [4:0]      m_rd;
   bit              m_rdw;

   always #5 clk = ~clk;

   operand_fetch #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in),
      .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .rd_write(rd_write),
      .regA_addr_out(regA_addr_out), .regB_addr_out(regB_addr_out),
      .regA_data_in(regA_data_in), .regB_data_in(regB_data_in),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush), .op_valid(op_valid), .op_ready(op_ready),
      .opA_out(opA_out), .opB_out(opB_out),
      .op_rd_out(op_rd_out), .op_rd_write_out(op_rd_write_out)
   );

   function automatic logic [31:0] m_busy_word();
      logic [31:0] w = '0;
      for (int i = 1; i < 32; i++) w[i] = m_busy[i];
      return w;
   endfunction

   function automatic bit m_haz(input bit use_it, input logic [4:0] a);
      return use_it && (a != 0) && m_busy[a] && !(wb_valid && wb_addr == a);
   endfunction

   function automatic bit m_ready();
      return (!m_opv || op_ready) && !m_haz(uses_rs1, rs1_addr_in)
             && !m_haz(uses_rs2, rs2_addr_in) && !m_haz(rd_write, rd_addr_in) && !flush;
   endfunction

   function automatic logic [XLEN-1:0] m_operand(input bit u, input logic [4:0] a);
      if (!u || a == 0) return '0;
      if (wb_valid && wb_addr == a) return wb_data;
      return rf[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_opv = 1'b0; m_a = '0; m_b = '0; m_rd = '0; m_rdw = 1'b0;
   endtask

   task automatic set_idle();
      issue_valid = 0; uses_rs1 = 0; uses_rs2 = 0; rd_write = 0;
      rs1_addr_in = 0; rs2_addr_in = 0; rd_addr_in = 0;
      wb_valid = 0; wb_addr = 0; wb_data = '0; flush = 0; op_ready = 1;
   endtask

   task automatic set_issue(input logic [4:0] r1, input bit u1, input logic [4:0] r2,
                            input bit u2, input logic [4:0] rd, input bit rw);
      issue_valid = 1; rs1_addr_in = r1; uses_rs1 = u1; rs2_addr_in = r2; uses_rs2 = u2;
      rd_addr_in = rd; rd_write = rw;
   endtask

   // one clock: model consumes the inputs held across the edge, outputs sampled 1 after it
   task automatic tick();
      bit acc;
      logic [XLEN-1:0] na, nb;
      acc = issue_valid && m_ready();
      na  = m_operand(uses_rs1, rs1_addr_in);
      nb  = m_operand(uses_rs2, rs2_addr_in);
      @(posedge clk);
      #1;
      if (flush) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         m_opv = 1'b0;
      end else begin
         if (wb_valid && wb_addr != 0) m_busy[wb_addr] = 1'b0;
         if (acc && rd_write && rd_addr_in != 0) m_busy[rd_addr_in] = 1'b1;
         if (acc) begin
            m_opv = 1'b1; m_a = na; m_b = nb; m_rd = rd_addr_in;
            m_rdw = rd_write && (rd_addr_in != 0);
         end else if (op_ready) begin
            m_opv = 1'b0;
         end
      end
      if (wb_valid && wb_addr != 0) rf[wb_addr] = wb_data;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set_idle();
      set_issue(5'd3, 1, 5'd4, 1, 5'd5, 1);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", issue_ready); end
      n_cmp++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL reset_op_valid got %b want 0", op_valid); end
      n_cmp++; if (opA_out !== '0 || opB_out !== '0) begin n_err++; $display("FAIL reset_ops got %h/%h want 0", opA_out, opB_out); end
      n_cmp++; if (op_rd_out !== 5'd0 || op_rd_write_out !== 1'b0) begin n_err++; $display("FAIL reset_rd got %0d/%b want 0/0", op_rd_out, op_rd_write_out); end
      n_cmp++; if (dut.busy !== 32'd0) begin n_err++; $display("FAIL reset_busy got %h want 0", dut.busy); end
      #3 reset = 1'b1;
      set_idle();
      tick();
   endtask

   task automatic test_basic();
      rf[5] = 64'h11;
      set_idle();
      set_issue(5'd5, 1, 5'd0, 1, 5'd6, 1);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready got %b want 1", issue_ready); end
      n_cmp++; if (regA_addr_out !== 5'd5 || regB_addr_out !== 5'd0) begin n_err++; $display("FAIL basic_raddr got %0d/%0d want 5/0", regA_addr_out, regB_addr_out); end
      tick();
      n_cmp++; if (op_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", op_valid); end
      n_cmp++; if (opA_out !== 64'h11 || opB_out !== 64'h0) begin n_err++; $display("FAIL basic_ops got %h/%h want 11/0", opA_out, opB_out); end
      n_cmp++; if (op_rd_out !== 5'd6 || op_rd_write_out !== 1'b1) begin n_err++; $display("FAIL basic_rd got %0d/%b want 6/1", op_rd_out, op_rd_write_out); end
      n_cmp++; if (dut.busy[6] !== 1'b1) begin n_err++; $display("FAIL basic_busy6 got %b want 1", dut.busy[6]); end
   endtask

   task automatic test_raw_bypass();
      set_idle();
      set_issue(5'd6, 1, 5'd0, 0, 5'd8, 1);
      for (int k = 0; k < 2; k++) begin
         #1;
         n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall cyc %0d got %b want 0", k, issue_ready); end
         tick();
      end
      n_cmp++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL raw_drained got %b want 0", op_valid); end
      wb_valid = 1; wb_addr = 5'd6; wb_data = 64'hABCD;
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL raw_wb_ready got %b want 1", issue_ready); end
      tick();
      n_cmp++; if (opA_out !== 64'hABCD || op_rd_out !== 5'd8) begin n_err++; $display("FAIL raw_bypass got %h rd %0d want abcd rd 8", opA_out, op_rd_out); end
      n_cmp++; if (dut.busy[6] !== 1'b0 || dut.busy[8] !== 1'b1) begin n_err++; $display("FAIL raw_busy got b6=%b b8=%b want 0/1", dut.busy[6], dut.busy[8]); end
   endtask

   task automatic test_stall_back_to_back();
      set_idle();
      op_ready = 0;
      set_issue(5'd1, 1, 5'd2, 1, 5'd9, 1);
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready cyc %0d got %b want 0", k, issue_ready); end
         tick();
         n_cmp++; if (op_valid !== 1'b1 || opA_out !== 64'hABCD || op_rd_out !== 5'd8 || op_rd_write_out !== 1'b1)
            begin n_err++; $display("FAIL stall_hold cyc %0d got v=%b a=%h rd=%0d want 1/abcd/8", k, op_valid, opA_out, op_rd_out); end
      end
      op_ready = 1;
      for (int k = 0; k < 4; k++) begin
         set_issue(5'(k + 1), 1, 5'(k + 2), 1, 5'(10 + k), 1);
         #1;
         n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready %0d got %b want 1", k, issue_ready); end
         tick();
         n_cmp++; if (op_valid !== 1'b1 || opA_out !== rf[k + 1] || opB_out !== rf[k + 2] || op_rd_out !== 5'(10 + k))
            begin n_err++; $display("FAIL b2b_xfer %0d got v=%b a=%h b=%h rd=%0d want a=%h b=%h rd=%0d", k, op_valid, opA_out, opB_out, op_rd_out, rf[k + 1], rf[k + 2], 10 + k); end
      end
      issue_valid = 0;
      tick();
      n_cmp++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", op_valid); end
   endtask

   task automatic test_waw_set_wins();
      set_idle();
      set_issue(5'd0, 0, 5'd0, 0, 5'd7, 1);
      tick();
      n_cmp++; if (dut.busy[7] !== 1'b1) begin n_err++; $display("FAIL waw_busy7 got %b want 1", dut.busy[7]); end
      wb_valid = 1; wb_addr = 5'd7; wb_data = {$urandom, $urandom};
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL waw_wb_ready got %b want 1", issue_ready); end
      tick();
      n_cmp++; if (dut.busy[7] !== 1'b1 || op_rd_out !== 5'd7) begin n_err++; $display("FAIL waw_set_wins got b7=%b rd=%0d want 1/7", dut.busy[7], op_rd_out); end
      wb_valid = 0;
      set_issue(5'd0, 0, 5'd0, 0, 5'd0, 1);
      tick();
      n_cmp++; if (op_valid !== 1'b1 || op_rd_write_out !== 1'b0) begin n_err++; $display("FAIL rd0_write got v=%b w=%b want 1/0", op_valid, op_rd_write_out); end
      n_cmp++; if (dut.busy !== m_busy_word()) begin n_err++; $display("FAIL rd0_busy got %h want %h", dut.busy, m_busy_word()); end
   endtask

   task automatic test_flush();
      set_idle();
      flush = 1;
      tick();
      flush = 0;
      for (int k = 4; k < 8; k++) begin
         set_issue(5'd0, 0, 5'd0, 0, 5'(k), 1);
         tick();
      end
      n_cmp++; if (dut.busy !== 32'h0000_00F0 || op_valid !== 1'b1) begin n_err++; $display("FAIL flush_setup got busy=%h v=%b want f0/1", dut.busy, op_valid); end
      flush = 1;
      set_issue(5'd0, 0, 5'd0, 0, 5'd9, 1);
      #1;
      n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b want 0", issue_ready); end
      tick();
      n_cmp++; if (dut.busy !== 32'd0 || op_valid !== 1'b0) begin n_err++; $display("FAIL flush_clear got busy=%h v=%b want 0/0", dut.busy, op_valid); end
      set_idle();
      tick();
      n_cmp++; if (op_valid !== 1'b0 || dut.busy !== 32'd0) begin n_err++; $display("FAIL flush_no_accept got busy=%h v=%b want 0/0", dut.busy, op_valid); end
   endtask

   task automatic test_reset_mid();
      set_idle();
      set_issue(5'd2, 1, 5'd3, 1, 5'd12, 1);
      tick();
      op_ready = 0;
      issue_valid = 0;
      #2 reset = 1'b0;
      #1;
      model_reset();
      n_cmp++; if (op_valid !== 1'b0 || opA_out !== '0 || op_rd_out !== 5'd0) begin n_err++; $display("FAIL rstmid_async got v=%b a=%h rd=%0d want 0", op_valid, opA_out, op_rd_out); end
      n_cmp++; if (issue_ready !== 1'b0 || dut.busy !== 32'd0) begin n_err++; $display("FAIL rstmid_ready got r=%b busy=%h want 0/0", issue_ready, dut.busy); end
      @(posedge clk);
      #3 reset = 1'b1;
      set_idle();
      rf[2] = {$urandom, $urandom};
      set_issue(5'd2, 1, 5'd0, 0, 5'd12, 1);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_rel_ready got %b want 1", issue_ready); end
      tick();
      n_cmp++; if (op_valid !== 1'b1 || opA_out !== rf[2] || op_rd_out !== 5'd12) begin n_err++; $display("FAIL rstmid_first got v=%b a=%h rd=%0d want 1/%h/12", op_valid, opA_out, op_rd_out, rf[2]); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 500; it++) begin
         issue_valid = ($urandom_range(0, 9) < 8);
         rs1_addr_in = 5'($urandom_range(0, 7));
         rs2_addr_in = 5'($urandom_range(0, 7));
         rd_addr_in  = 5'($urandom_range(0, 7));
         uses_rs1 = $urandom_range(0, 1); uses_rs2 = $urandom_range(0, 1);
         rd_write = ($urandom_range(0, 3) != 0);
         wb_valid = ($urandom_range(0, 9) < 4);
         wb_addr  = 5'($urandom_range(0, 7));
         wb_data  = {$urandom, $urandom};
         flush    = ($urandom_range(0, 19) == 0);
         op_ready = ($urandom_range(0, 9) < 7);
         #1;
         n_cmp++; if (issue_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready it %0d got %b want %b", it, issue_ready, m_ready()); end
         tick();
         n_cmp++; if (op_valid !== m_opv || dut.busy !== m_busy_word()) begin n_err++; $display("FAIL rnd_state it %0d got v=%b busy=%h want v=%b busy=%h", it, op_valid, dut.busy, m_opv, m_busy_word()); end
         if (m_opv) begin
            n_cmp++; if (opA_out !== m_a || opB_out !== m_b || op_rd_out !== m_rd || op_rd_write_out !== m_rdw)
               begin n_err++; $display("FAIL rnd_bundle it %0d got %h %h %0d %b want %h %h %0d %b", it, opA_out, opB_out, op_rd_out, op_rd_write_out, m_a, m_b, m_rd, m_rdw); end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
      test_reset();
      test_basic();
      test_raw_bypass();
      test_stall_back_to_back();
      test_waw_set_wins();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
